// File: rtl/core_dispatcher.sv
// Instruction issuer for the HDC core: buffers packed 16-bit ops from a 32-bit stream,
// drives run/get_v/get_d/exec, and reports completion with a done pulse.
module core_dispatcher #(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        s_valid,
   input  logic [31:0] s_data,
   input  logic        s_last,
   output logic        s_ready,
   input  logic        core_last,
   output logic        run,
   output logic        get_v,
   output logic [15:0] get_d,
   output logic        exec,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [15:0]     mem_q [DEPTH];
   logic [15:0]     mem_d [DEPTH];
   logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic            run_q, run_d;
   logic            get_v_q, get_v_d;
   logic [15:0]     get_d_q, get_d_d;
   logic            exec_q, exec_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            stream_end_q, stream_end_d;
   logic            drop_q, drop_d;

   logic [PW-1:0]   wr_p1, count;
   logic            empty, can_push2, accept;
   logic [15:0]     head;

   always_comb begin
      wr_p1     = wr_q + PW'(1);
      count     = wr_q - rd_q;
      empty     = (wr_q == rd_q);
      can_push2 = (count <= PW'(DEPTH - 2));
      head      = mem_q[rd_q[AW-1:0]];
      // While dropping the tail of an aborted stream, words are taken and discarded.
      s_ready   = (state_q != ST_IDLE) &
                  (drop_q | ((state_q == ST_RUN) & ~stream_end_q & can_push2));
      accept    = s_valid & s_ready;
   end

   always_comb begin
      state_d      = state_q;
      mem_d        = mem_q;
      wr_d         = wr_q;
      rd_d         = rd_q;
      tcnt_d       = tcnt_q;
      run_d        = run_q;
      get_v_d      = 1'b0;
      get_d_d      = '0;
      exec_d       = get_v_q;
      done_d       = 1'b0;
      err_d        = err_q;
      stream_end_d = stream_end_q;
      drop_d       = drop_q;

      if (accept && !drop_q) begin
         mem_d[wr_q[AW-1:0]]  = s_data[15:0];
         mem_d[wr_p1[AW-1:0]] = s_data[31:16];
         wr_d                 = wr_q + PW'(2);
         if (s_last) stream_end_d = 1'b1;
      end
      if (accept && drop_q && s_last) drop_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d      = ST_RUN;
               run_d        = 1'b1;
               err_d        = 1'b0;
               wr_d         = '0;
               rd_d         = '0;
               tcnt_d       = '0;
               stream_end_d = 1'b0;
               drop_d       = 1'b0;
            end
         end
         ST_RUN: begin
            if (!empty) begin
               get_v_d = 1'b1;
               get_d_d = head;
               rd_d    = rd_q + PW'(1);
               if (head[15:10] == 6'b000001) begin
                  // Flush includes anything pushed this same cycle.
                  rd_d    = wr_d;
                  drop_d  = ~stream_end_d;
                  tcnt_d  = '0;
                  state_d = ST_WAIT;
               end
            end else if (stream_end_q) begin
               get_v_d = 1'b1;
               get_d_d = 16'h0400;
               err_d   = 1'b1;
               tcnt_d  = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (core_last) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               run_d   = 1'b0;
            end else if (tcnt_q == TW'(TIMEOUT)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               run_d   = 1'b0;
               err_d   = 1'b1;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         mem_q        <= '{default: '0};
         wr_q         <= '0;
         rd_q         <= '0;
         tcnt_q       <= '0;
         run_q        <= 1'b0;
         get_v_q      <= 1'b0;
         get_d_q      <= '0;
         exec_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         stream_end_q <= 1'b0;
         drop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         mem_q        <= mem_d;
         wr_q         <= wr_d;
         rd_q         <= rd_d;
         tcnt_q       <= tcnt_d;
         run_q        <= run_d;
         get_v_q      <= get_v_d;
         get_d_q      <= get_d_d;
         exec_q       <= exec_d;
         done_q       <= done_d;
         err_q        <= err_d;
         stream_end_q <= stream_end_d;
         drop_q       <= drop_d;
      end
   end

   assign run   = run_q;
   assign get_v = get_v_q;
   assign get_d = get_d_q;
   assign exec  = exec_q;
   assign busy  = (state_q != ST_IDLE);
   assign done  = done_q;
   assign err   = err_q;

endmodule
